id_ex_stage: RTL and testbench

//  ID/EX pipeline register with operand forwarding and load-use hazard detection.

---
 rtl/id_ex_stage_pkg.sv | 19 +
 rtl/id_ex_stage_operand_fwd.sv | 47 ++++
 rtl/id_ex_stage.sv | 154 +++++++++++++++
 tb/tb_id_ex_stage.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared CPU widths and forwarding-source encoding for the ID/EX stage.
package id_ex_stage_pkg;

    localparam int CPU_PC_W  = 5;
    localparam int CPU_XLEN  = 32;
    localparam int CPU_RA_W  = 5;
    localparam int CPU_OP_W  = 5;
    localparam int CPU_CNT_W = 16;

    localparam logic [CPU_RA_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_ID  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_src_e;

endpackage

// File: rtl/id_ex_stage_operand_fwd.sv
// Operand forwarding mux: newest producer wins (EX > MEM > WB); x0 always reads the register file.
module operand_fwd
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = CPU_XLEN,
    parameter int RA_W = CPU_RA_W
) (
    input  logic [RA_W-1:0] rs,
    input  logic [XLEN-1:0] id_rd,
    input  logic            ex_en,
    input  logic [RA_W-1:0] ex_reg,
    input  logic [XLEN-1:0] ex_data,
    input  logic            mem_en,
    input  logic [RA_W-1:0] mem_reg,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_en,
    input  logic [RA_W-1:0] wb_reg,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] fwd_data
);

    fwd_src_e src;

    always_comb begin
        src = FWD_ID;
        if (rs != RA_W'(REG_ZERO)) begin
            if (ex_en && (ex_reg == rs)) begin
                src = FWD_EX;
            end else if (mem_en && (mem_reg == rs)) begin
                src = FWD_MEM;
            end else if (wb_en && (wb_reg == rs)) begin
                src = FWD_WB;
            end
        end
    end

    always_comb begin
        fwd_data = id_rd;
        case (src)
            FWD_EX:  fwd_data = ex_data;
            FWD_MEM: fwd_data = mem_data;
            FWD_WB:  fwd_data = wb_data;
            default: fwd_data = id_rd;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use stall/bubble insertion.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int PC_W  = CPU_PC_W,
    parameter int XLEN  = CPU_XLEN,
    parameter int RA_W  = CPU_RA_W,
    parameter int OP_W  = CPU_OP_W,
    parameter int CNT_W = CPU_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [PC_W-1:0]  id_pc,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [XLEN-1:0]  id_rd1,
    input  logic [XLEN-1:0]  id_rd2,
    input  logic [XLEN-1:0]  id_imm,
    input  logic             id_alu_src,
    input  logic             id_is_jump,
    input  logic             id_reg_wrenable,
    input  logic             id_mem_wrenable,
    input  logic             id_mem_to_reg,
    input  logic [OP_W-1:0]  id_alu_op,
    input  logic [RA_W-1:0]  id_write_reg,
    input  logic [XLEN-1:0]  ex_fwd_data,
    input  logic             mem_valid,
    input  logic             mem_reg_wrenable,
    input  logic [RA_W-1:0]  mem_write_reg,
    input  logic [XLEN-1:0]  mem_fwd_data,
    input  logic             wb_valid,
    input  logic             wb_reg_wrenable,
    input  logic [RA_W-1:0]  wb_write_reg,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             flush,
    output logic             stall_id,
    output logic             ex_valid,
    output logic [PC_W-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rd1,
    output logic [XLEN-1:0]  ex_rd2,
    output logic [XLEN-1:0]  ex_imm,
    output logic             ex_alu_src,
    output logic [OP_W-1:0]  ex_alu_op,
    output logic             ex_is_jump,
    output logic             ex_reg_wrenable,
    output logic [RA_W-1:0]  ex_write_reg,
    output logic             ex_mem_wrenable,
    output logic             ex_mem_to_reg,
    output logic [CNT_W-1:0] stall_cnt
);

    logic            lu_hit;
    logic            ex_fwd_en;
    logic            mem_fwd_en;
    logic            wb_fwd_en;
    logic [XLEN-1:0] fwd_rd1;
    logic [XLEN-1:0] fwd_rd2;

    // A load in EX has no data yet, so it must not forward and instead forces a stall.
    assign lu_hit = ex_valid && ex_mem_to_reg && ex_reg_wrenable &&
                    (ex_write_reg != RA_W'(REG_ZERO)) && id_valid &&
                    ((id_uses_rs1 && (id_rs1 == ex_write_reg)) ||
                     (id_uses_rs2 && (id_rs2 == ex_write_reg)));

    assign stall_id   = lu_hit && !flush;
    assign ex_fwd_en  = ex_valid && ex_reg_wrenable && !ex_mem_to_reg;
    assign mem_fwd_en = mem_valid && mem_reg_wrenable;
    assign wb_fwd_en  = wb_valid && wb_reg_wrenable;

    operand_fwd #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
        .rs       (id_rs1),
        .id_rd    (id_rd1),
        .ex_en    (ex_fwd_en),
        .ex_reg   (ex_write_reg),
        .ex_data  (ex_fwd_data),
        .mem_en   (mem_fwd_en),
        .mem_reg  (mem_write_reg),
        .mem_data (mem_fwd_data),
        .wb_en    (wb_fwd_en),
        .wb_reg   (wb_write_reg),
        .wb_data  (wb_data),
        .fwd_data (fwd_rd1)
    );

    operand_fwd #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
        .rs       (id_rs2),
        .id_rd    (id_rd2),
        .ex_en    (ex_fwd_en),
        .ex_reg   (ex_write_reg),
        .ex_data  (ex_fwd_data),
        .mem_en   (mem_fwd_en),
        .mem_reg  (mem_write_reg),
        .mem_data (mem_fwd_data),
        .wb_en    (wb_fwd_en),
        .wb_reg   (wb_write_reg),
        .wb_data  (wb_data),
        .fwd_data (fwd_rd2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid        <= 1'b0;
            ex_pc           <= '0;
            ex_rd1          <= '0;
            ex_rd2          <= '0;
            ex_imm          <= '0;
            ex_alu_src      <= 1'b0;
            ex_alu_op       <= '0;
            ex_is_jump      <= 1'b0;
            ex_reg_wrenable <= 1'b0;
            ex_write_reg    <= '0;
            ex_mem_wrenable <= 1'b0;
            ex_mem_to_reg   <= 1'b0;
        end else if (flush || lu_hit) begin
            ex_valid        <= 1'b0;
            ex_pc           <= '0;
            ex_rd1          <= '0;
            ex_rd2          <= '0;
            ex_imm          <= '0;
            ex_alu_src      <= 1'b0;
            ex_alu_op       <= '0;
            ex_is_jump      <= 1'b0;
            ex_reg_wrenable <= 1'b0;
            ex_write_reg    <= '0;
            ex_mem_wrenable <= 1'b0;
            ex_mem_to_reg   <= 1'b0;
        end else begin
            ex_valid        <= id_valid;
            ex_pc           <= id_pc;
            ex_rd1          <= fwd_rd1;
            ex_rd2          <= fwd_rd2;
            ex_imm          <= id_imm;
            ex_alu_src      <= id_alu_src;
            ex_alu_op       <= id_alu_op;
            ex_is_jump      <= id_is_jump;
            ex_reg_wrenable <= id_reg_wrenable && id_valid;
            ex_write_reg    <= id_write_reg;
            ex_mem_wrenable <= id_mem_wrenable && id_valid;
            ex_mem_to_reg   <= id_mem_to_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_id && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic against a behavioural model.
module tb_id_ex_stage;

    localparam int PC_W  = 5;
    localparam int XLEN  = 32;
    localparam int RA_W  = 5;
    localparam int OP_W  = 5;
    localparam int CNT_W = 4;
    localparam int BUS_W = 1 + PC_W + 3*XLEN + 1 + OP_W + 1 + 1 + RA_W + 1 + 1;

    logic             clk;
    logic             rst;
    logic             id_valid;
    logic [PC_W-1:0]  id_pc;
    logic [RA_W-1:0]  id_rs1, id_rs2;
    logic             id_uses_rs1, id_uses_rs2;
    logic [XLEN-1:0]  id_rd1, id_rd2, id_imm;
    logic             id_alu_src, id_is_jump, id_reg_wrenable, id_mem_wrenable, id_mem_to_reg;
    logic [OP_W-1:0]  id_alu_op;
    logic [RA_W-1:0]  id_write_reg;
    logic [XLEN-1:0]  ex_fwd_data;
    logic             mem_valid, mem_reg_wrenable;
    logic [RA_W-1:0]  mem_write_reg;
    logic [XLEN-1:0]  mem_fwd_data;
    logic             wb_valid, wb_reg_wrenable;
    logic [RA_W-1:0]  wb_write_reg;
    logic [XLEN-1:0]  wb_data;
    logic             flush;
    logic             stall_id;
    logic             ex_valid;
    logic [PC_W-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_rd1, ex_rd2, ex_imm;
    logic             ex_alu_src;
    logic [OP_W-1:0]  ex_alu_op;
    logic             ex_is_jump, ex_reg_wrenable;
    logic [RA_W-1:0]  ex_write_reg;
    logic             ex_mem_wrenable, ex_mem_to_reg;
    logic [CNT_W-1:0] stall_cnt;

    id_ex_stage #(.PC_W(PC_W), .XLEN(XLEN), .RA_W(RA_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_is_jump(id_is_jump), .id_reg_wrenable(id_reg_wrenable),
        .id_mem_wrenable(id_mem_wrenable), .id_mem_to_reg(id_mem_to_reg),
        .id_alu_op(id_alu_op), .id_write_reg(id_write_reg),
        .ex_fwd_data(ex_fwd_data),
        .mem_valid(mem_valid), .mem_reg_wrenable(mem_reg_wrenable),
        .mem_write_reg(mem_write_reg), .mem_fwd_data(mem_fwd_data),
        .wb_valid(wb_valid), .wb_reg_wrenable(wb_reg_wrenable),
        .wb_write_reg(wb_write_reg), .wb_data(wb_data),
        .flush(flush), .stall_id(stall_id),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_is_jump(ex_is_jump),
        .ex_reg_wrenable(ex_reg_wrenable), .ex_write_reg(ex_write_reg),
        .ex_mem_wrenable(ex_mem_wrenable), .ex_mem_to_reg(ex_mem_to_reg),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Model of the instruction sitting in EX.
    logic             m_valid;
    logic [PC_W-1:0]  m_pc;
    logic [XLEN-1:0]  m_rd1, m_rd2, m_imm;
    logic             m_alu_src, m_is_jump, m_reg_we, m_mem_we, m_mem_to_reg;
    logic [OP_W-1:0]  m_alu_op;
    logic [RA_W-1:0]  m_write_reg;
    int               m_cnt;

    logic [BUS_W-1:0] dut_bus;
    assign dut_bus = {ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_alu_src, ex_alu_op,
                      ex_is_jump, ex_reg_wrenable, ex_write_reg, ex_mem_wrenable, ex_mem_to_reg};

    function automatic logic [BUS_W-1:0] exp_bus();
        return {m_valid, m_pc, m_rd1, m_rd2, m_imm, m_alu_src, m_alu_op,
                m_is_jump, m_reg_we, m_write_reg, m_mem_we, m_mem_to_reg};
    endfunction

    function automatic logic ref_lu();
        logic reads;
        reads = (id_uses_rs1 && id_rs1 == m_write_reg) || (id_uses_rs2 && id_rs2 == m_write_reg);
        return m_valid && m_mem_to_reg && m_reg_we && (m_write_reg != 0) && id_valid && reads;
    endfunction

    function automatic logic [XLEN-1:0] ref_fwd(input logic [RA_W-1:0] rs, input logic [XLEN-1:0] rd);
        logic            en  [3];
        logic [RA_W-1:0] wr  [3];
        logic [XLEN-1:0] dat [3];
        en[0] = m_valid && m_reg_we && !m_mem_to_reg; wr[0] = m_write_reg;   dat[0] = ex_fwd_data;
        en[1] = mem_valid && mem_reg_wrenable;        wr[1] = mem_write_reg; dat[1] = mem_fwd_data;
        en[2] = wb_valid && wb_reg_wrenable;          wr[2] = wb_write_reg;  dat[2] = wb_data;
        if (rs == 0) return rd;
        for (int i = 0; i < 3; i++) begin
            if (en[i] && wr[i] == rs) return dat[i];
        end
        return rd;
    endfunction

    task automatic ref_clear_ex();
        m_valid = 0; m_pc = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_alu_src = 0;
        m_alu_op = '0; m_is_jump = 0; m_reg_we = 0; m_write_reg = '0; m_mem_we = 0; m_mem_to_reg = 0;
    endtask

    // Advance one clock edge and move the model along with the DUT.
    task automatic cycle();
        logic            lu, stall;
        logic [XLEN-1:0] f1, f2;
        lu    = ref_lu();
        stall = lu && !flush;
        f1    = ref_fwd(id_rs1, id_rd1);
        f2    = ref_fwd(id_rs2, id_rd2);
        @(posedge clk);
        if (flush || lu) begin
            ref_clear_ex();
        end else begin
            m_valid = id_valid; m_pc = id_pc; m_rd1 = f1; m_rd2 = f2; m_imm = id_imm;
            m_alu_src = id_alu_src; m_alu_op = id_alu_op; m_is_jump = id_is_jump;
            m_reg_we = id_reg_wrenable && id_valid; m_write_reg = id_write_reg;
            m_mem_we = id_mem_wrenable && id_valid; m_mem_to_reg = id_mem_to_reg;
        end
        if (stall && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_rd1 = '0; id_rd2 = '0; id_imm = '0; id_alu_src = 0; id_is_jump = 0;
        id_reg_wrenable = 0; id_mem_wrenable = 0; id_mem_to_reg = 0; id_alu_op = '0;
        id_write_reg = '0; ex_fwd_data = '0; mem_valid = 0; mem_reg_wrenable = 0;
        mem_write_reg = '0; mem_fwd_data = '0; wb_valid = 0; wb_reg_wrenable = 0;
        wb_write_reg = '0; wb_data = '0; flush = 0;
    endtask

    task automatic put_load_in_ex(input logic [RA_W-1:0] rd);
        clear_inputs();
        id_valid = 1; id_reg_wrenable = 1; id_mem_to_reg = 1; id_write_reg = rd;
        cycle();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        #2;
        n_vec++;
        if (dut_bus !== '0 || stall_cnt !== '0) begin
            n_miss++;
            $display("FAIL reset_state: got bus=%h cnt=%h want 0", dut_bus, stall_cnt);
        end
        ref_clear_ex(); m_cnt = 0;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_fwd_ex();
        clear_inputs();
        id_valid = 1; id_reg_wrenable = 1; id_write_reg = 5'd3;
        cycle();
        clear_inputs();
        ex_fwd_data = 32'h10; id_valid = 1; id_uses_rs1 = 1; id_rs1 = 5'd3; id_rd1 = 32'hDEAD;
        cycle();
        n_vec++;
        if (ex_rd1 !== 32'h10 || dut_bus !== exp_bus()) begin
            n_miss++;
            $display("FAIL fwd_ex: got ex_rd1=%h want 10", ex_rd1);
        end
    endtask

    task automatic test_load_use();
        put_load_in_ex(5'd5);
        clear_inputs();
        id_valid = 1; id_uses_rs2 = 1; id_rs2 = 5'd5; id_rd2 = 32'hBAD;
        #1;
        n_vec++;
        if (stall_id !== 1'b1) begin
            n_miss++;
            $display("FAIL lu_stall: got stall_id=%b want 1", stall_id);
        end
        cycle();
        n_vec++;
        if (ex_valid !== 1'b0 || stall_cnt !== 4'd1 || dut_bus !== exp_bus()) begin
            n_miss++;
            $display("FAIL lu_bubble: got ex_valid=%b cnt=%0d want 0 and 1", ex_valid, stall_cnt);
        end
        mem_valid = 1; mem_reg_wrenable = 1; mem_write_reg = 5'd5; mem_fwd_data = 32'h77;
        #1;
        n_vec++;
        if (stall_id !== 1'b0) begin
            n_miss++;
            $display("FAIL lu_release: got stall_id=%b want 0", stall_id);
        end
        cycle();
        n_vec++;
        if (ex_rd2 !== 32'h77 || ex_valid !== 1'b1) begin
            n_miss++;
            $display("FAIL lu_mem_fwd: got ex_rd2=%h valid=%b want 77 and 1", ex_rd2, ex_valid);
        end
    endtask

    task automatic test_priority();
        logic [XLEN-1:0] want [3];
        want[0] = 32'd1; want[1] = 32'd2; want[2] = 32'd3;
        clear_inputs();
        id_valid = 1; id_reg_wrenable = 1; id_write_reg = 5'd7;
        cycle();
        clear_inputs();
        ex_fwd_data = 32'd1;
        mem_valid = 1; mem_reg_wrenable = 1; mem_write_reg = 5'd7; mem_fwd_data = 32'd2;
        wb_valid = 1;  wb_reg_wrenable = 1;  wb_write_reg = 5'd7;  wb_data = 32'd3;
        id_valid = 1; id_uses_rs1 = 1; id_rs1 = 5'd7; id_rd1 = 32'hAAAA;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) mem_valid = 0;
            cycle();
            n_vec++;
            if (ex_rd1 !== want[k] || dut_bus !== exp_bus()) begin
                n_miss++;
                $display("FAIL priority_%0d: got ex_rd1=%h want %h", k, ex_rd1, want[k]);
            end
        end
    endtask

    task automatic test_x0();
        clear_inputs();
        id_valid = 1; id_reg_wrenable = 1; id_write_reg = 5'd0;
        cycle();
        clear_inputs();
        ex_fwd_data = 32'hFF;
        mem_valid = 1; mem_reg_wrenable = 1; mem_write_reg = 5'd0; mem_fwd_data = 32'hFF;
        wb_valid = 1;  wb_reg_wrenable = 1;  wb_write_reg = 5'd0;  wb_data = 32'hFF;
        id_valid = 1; id_uses_rs1 = 1; id_uses_rs2 = 1;
        cycle();
        n_vec++;
        if (ex_rd1 !== '0 || ex_rd2 !== '0) begin
            n_miss++;
            $display("FAIL x0_guard: got rd1=%h rd2=%h want 0", ex_rd1, ex_rd2);
        end
    endtask

    task automatic test_flush_lu();
        int cnt_before;
        put_load_in_ex(5'd5);
        cnt_before = m_cnt;
        clear_inputs();
        id_valid = 1; id_uses_rs1 = 1; id_rs1 = 5'd5; id_reg_wrenable = 1; id_mem_wrenable = 1;
        flush = 1;
        #1;
        n_vec++;
        if (stall_id !== 1'b0) begin
            n_miss++;
            $display("FAIL flush_lu_stall: got stall_id=%b want 0", stall_id);
        end
        cycle();
        n_vec++;
        if (ex_valid !== 0 || ex_reg_wrenable !== 0 || ex_mem_wrenable !== 0 ||
            int'(stall_cnt) != cnt_before) begin
            n_miss++;
            $display("FAIL flush_lu_bubble: got v=%b rwe=%b mwe=%b cnt=%0d want 0 0 0 %0d",
                     ex_valid, ex_reg_wrenable, ex_mem_wrenable, stall_cnt, cnt_before);
        end
        flush = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            id_valid = ($urandom_range(0, 7) != 0);
            id_pc = PC_W'($urandom);
            id_rs1 = RA_W'($urandom_range(0, 3)); id_rs2 = RA_W'($urandom_range(0, 3));
            id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
            id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
            id_alu_src = 1'($urandom); id_is_jump = 1'($urandom);
            id_reg_wrenable = 1'($urandom); id_mem_wrenable = 1'($urandom);
            id_mem_to_reg = 1'($urandom); id_alu_op = OP_W'($urandom);
            id_write_reg = RA_W'($urandom_range(0, 3));
            ex_fwd_data = $urandom;
            mem_valid = 1'($urandom); mem_reg_wrenable = 1'($urandom);
            mem_write_reg = RA_W'($urandom_range(0, 3)); mem_fwd_data = $urandom;
            wb_valid = 1'($urandom); wb_reg_wrenable = 1'($urandom);
            wb_write_reg = RA_W'($urandom_range(0, 3)); wb_data = $urandom;
            flush = ($urandom_range(0, 7) == 0);
            #1;
            n_vec++;
            if (stall_id !== (ref_lu() && !flush)) begin
                n_miss++;
                $display("FAIL rand_stall %0d: got %b want %b", i, stall_id, ref_lu() && !flush);
            end
            cycle();
            n_vec++;
            if (dut_bus !== exp_bus() || int'(stall_cnt) != m_cnt) begin
                n_miss++;
                $display("FAIL rand_ex %0d: got %h cnt=%0d want %h cnt=%0d",
                         i, dut_bus, stall_cnt, exp_bus(), m_cnt);
            end
        end
        flush = 0;
    endtask

    task automatic test_reset_mid();
        put_load_in_ex(5'd2);
        clear_inputs();
        id_valid = 1; id_uses_rs1 = 1; id_rs1 = 5'd2;
        cycle();
        clear_inputs();
        id_valid = 1; id_pc = 5'd9; id_imm = 32'h1234; id_reg_wrenable = 1; id_write_reg = 5'd4;
        cycle();
        #3 rst = 1;
        #1;
        n_vec++;
        if (dut_bus !== '0 || stall_cnt !== '0) begin
            n_miss++;
            $display("FAIL reset_mid: got bus=%h cnt=%h want 0", dut_bus, stall_cnt);
        end
        ref_clear_ex(); m_cnt = 0;
        #1 rst = 0;
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 20; k++) begin
            put_load_in_ex(5'd6);
            clear_inputs();
            id_valid = 1; id_uses_rs1 = 1; id_rs1 = 5'd6;
            cycle();
            n_vec++;
            if (int'(stall_cnt) != m_cnt) begin
                n_miss++;
                $display("FAIL sat_step %0d: got %0d want %0d", k, stall_cnt, m_cnt);
            end
        end
        n_vec++;
        if (stall_cnt !== {CNT_W{1'b1}}) begin
            n_miss++;
            $display("FAIL sat_hold: got %h want all-ones", stall_cnt);
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        test_reset();
        test_fwd_ex();
        test_load_use();
        test_priority();
        test_x0();
        test_flush_lu();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
